data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 99 +++++++++
 tb/tb_data_memory.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Byte-addressed, little-endian RV64 data memory with combinational loads,
// edge-committed stores, per-access fault detection and store/fault bookkeeping.
module data_memory #(
    parameter int DEPTH_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] Mem_Addr,
    input  logic [63:0] Write_Data,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    output logic [63:0] Read_Data,
    output logic        Fault,
    output logic        Fault_Sticky,
    output logic [31:0] Store_Count
);

    localparam int AW = $clog2(DEPTH_BYTES);
    typedef logic [AW-1:0] idx_t;

    logic [7:0]  mem_q [DEPTH_BYTES];
    logic [7:0]  mem_d [DEPTH_BYTES];
    logic [31:0] store_count_q, store_count_d;
    logic        fault_sticky_q, fault_sticky_d;

    idx_t        base_s;
    logic [2:0]  mask_s;
    logic [AW:0] last_s;
    logic        misalign_s, range_s, ld_fault_s, st_fault_s;
    logic [63:0] raw_s, ext_s;

    // Access-size decode and fault detection; mask_s is size-1 (0,1,3,7)
    always_comb begin
        base_s     = Mem_Addr[AW-1:0];
        mask_s     = {funct3[1] & funct3[0], funct3[1], funct3[1] | funct3[0]};
        misalign_s = |(Mem_Addr[2:0] & mask_s);
        last_s     = (AW+1)'(base_s) + (AW+1)'(mask_s);
        range_s    = last_s[AW] | (|Mem_Addr[63:AW]);
        ld_fault_s = MemRead  & ((funct3 == 3'b111) | misalign_s | range_s);
        st_fault_s = MemWrite & (funct3[2] | misalign_s | range_s);
        Fault      = ld_fault_s | st_fault_s;
    end

    // Combinational load path: gather 8 bytes, then size and extend
    always_comb begin
        raw_s = 64'd0;
        for (int i = 0; i < 8; i++) begin
            raw_s[8*i +: 8] = mem_q[idx_t'(base_s + idx_t'(i))];
        end
        case (funct3[1:0])
            2'b00:   ext_s = {{56{~funct3[2] & raw_s[7]}},  raw_s[7:0]};
            2'b01:   ext_s = {{48{~funct3[2] & raw_s[15]}}, raw_s[15:0]};
            2'b10:   ext_s = {{32{~funct3[2] & raw_s[31]}}, raw_s[31:0]};
            2'b11:   ext_s = raw_s;
            default: ext_s = 64'd0;
        endcase
        if (MemRead && !ld_fault_s) begin
            Read_Data = ext_s;
        end else begin
            Read_Data = 64'd0;
        end
    end

    // Next-state: byte-lane store merge, store counter, sticky fault
    always_comb begin
        mem_d          = mem_q;
        store_count_d  = store_count_q;
        fault_sticky_d = fault_sticky_q | Fault;
        if (MemWrite && !st_fault_s) begin
            for (int i = 0; i < 8; i++) begin
                mem_d[idx_t'(base_s + idx_t'(i))] = (3'(i) <= mask_s) ?
                    Write_Data[8*i +: 8] : mem_q[idx_t'(base_s + idx_t'(i))];
            end
            store_count_d = store_count_q + 32'd1;
        end else begin
            store_count_d = store_count_q;
        end
    end

    // State registers; reset clears the whole array asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem_q[i] <= 8'd0;
            end
            store_count_q  <= 32'd0;
            fault_sticky_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            store_count_q  <= store_count_d;
            fault_sticky_q <= fault_sticky_d;
        end
    end

    assign Store_Count  = store_count_q;
    assign Fault_Sticky = fault_sticky_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (DEPTH_BYTES = 256).
module tb_data_memory;

    logic        clk;
    logic        reset;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  funct3;
    logic [63:0] Read_Data;
    logic        Fault;
    logic        Fault_Sticky;
    logic [31:0] Store_Count;

    int n_total = 0;
    int n_pass  = 0;

    data_memory #(.DEPTH_BYTES(256)) dut (
        .clk(clk), .reset(reset), .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
        .MemWrite(MemWrite), .MemRead(MemRead), .funct3(funct3),
        .Read_Data(Read_Data), .Fault(Fault), .Fault_Sticky(Fault_Sticky),
        .Store_Count(Store_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; Mem_Addr = a; Write_Data = d;
        #1;
    endtask

    initial begin
        // Reset asserted with a store request pending on every edge
        reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b1; funct3 = 3'b011;
        Mem_Addr = 64'h20; Write_Data = 64'hFFFF_FFFF_FFFF_FFFF;
        #12;
        chk("rst_read",   Read_Data, 64'd0);
        chk("rst_count",  64'(Store_Count), 64'd0);
        chk("rst_sticky", 64'(Fault_Sticky), 64'd0);
        @(negedge clk);
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;

        // Store and reload
        op(1'b0, 1'b1, 3'b011, 64'h10, 64'h8877_6655_4433_2211);
        chk("sd_fault", 64'(Fault), 64'd0);
        op(1'b1, 1'b0, 3'b000, 64'h17, 64'd0);
        chk("lb_17",    Read_Data, 64'hFFFF_FFFF_FFFF_FF88);
        chk("count_1",  64'(Store_Count), 64'd1);
        op(1'b1, 1'b0, 3'b100, 64'h17, 64'd0);
        chk("lbu_17",   Read_Data, 64'h88);
        op(1'b1, 1'b0, 3'b010, 64'h10, 64'd0);
        chk("lw_10",    Read_Data, 64'h0000_0000_4433_2211);
        op(1'b1, 1'b0, 3'b011, 64'h20, 64'd0);
        chk("rst_store_discarded", Read_Data, 64'd0);

        // Partial store only touches two bytes
        op(1'b0, 1'b1, 3'b001, 64'h12, 64'h1234_5678_9ABC_BEEF);
        op(1'b1, 1'b0, 3'b011, 64'h10, 64'd0);
        chk("ld_after_sh", Read_Data, 64'h8877_6655_BEEF_2211);
        chk("count_2",     64'(Store_Count), 64'd2);
        op(1'b1, 1'b0, 3'b101, 64'h12, 64'd0);
        chk("lhu_12",      Read_Data, 64'h0000_0000_0000_BEEF);
        op(1'b1, 1'b0, 3'b001, 64'h12, 64'd0);
        chk("lh_12",       Read_Data, 64'hFFFF_FFFF_FFFF_BEEF);

        // Misaligned store
        op(1'b0, 1'b1, 3'b010, 64'h06, 64'h0000_0000_DEAD_BEEF);
        chk("sw_06_fault",     64'(Fault), 64'd1);
        chk("sticky_pre_edge", 64'(Fault_Sticky), 64'd0);
        op(1'b1, 1'b0, 3'b011, 64'h00, 64'd0);
        chk("sticky_set",      64'(Fault_Sticky), 64'd1);
        chk("sw_06_count",     64'(Store_Count), 64'd2);
        chk("sw_06_bytes_0",   Read_Data, 64'd0);
        op(1'b1, 1'b0, 3'b011, 64'h08, 64'd0);
        chk("sw_06_bytes_8",   Read_Data, 64'd0);

        // Last legal doubleword, then faulted sd over its upper half
        op(1'b0, 1'b1, 3'b011, 64'hF8, 64'h0102_0304_0506_0708);
        chk("sd_f8_fault", 64'(Fault), 64'd0);
        op(1'b0, 1'b1, 3'b011, 64'hFC, 64'hCCCC_CCCC_CCCC_CCCC);
        chk("sd_fc_fault", 64'(Fault), 64'd1);
        op(1'b1, 1'b0, 3'b110, 64'hFC, 64'd0);
        chk("lwu_fc",      Read_Data, 64'h0000_0000_0102_0304);
        chk("count_3",     64'(Store_Count), 64'd3);

        // Out-of-range addresses, including a high alias of a valid byte
        op(1'b0, 1'b1, 3'b000, 64'h100, 64'h77);
        chk("sb_100_fault", 64'(Fault), 64'd1);
        op(1'b1, 1'b0, 3'b011, 64'h8000_0000_0000_0010, 64'd0);
        chk("ld_alias_fault", 64'(Fault), 64'd1);
        chk("ld_alias_data",  Read_Data, 64'd0);
        op(1'b1, 1'b0, 3'b000, 64'h00, 64'd0);
        chk("sb_100_count",   64'(Store_Count), 64'd3);

        // Idle: inputs are ignored
        op(1'b0, 1'b0, 3'b111, 64'h06, 64'hFFFF);
        chk("idle_fault", 64'(Fault), 64'd0);
        chk("idle_read",  Read_Data, 64'd0);

        // Simultaneous read and write: no write-through
        op(1'b0, 1'b1, 3'b001, 64'h40, 64'h1234);
        op(1'b1, 1'b1, 3'b011, 64'h40, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("rw_old",  Read_Data, 64'h1234);
        op(1'b1, 1'b0, 3'b011, 64'h40, 64'd0);
        chk("rw_new",  Read_Data, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("count_5", 64'(Store_Count), 64'd5);
        op(1'b1, 1'b0, 3'b010, 64'h40, 64'd0);
        chk("lw_40",   Read_Data, 64'hFFFF_FFFF_AAAA_AAAA);

        // Illegal funct3
        op(1'b1, 1'b0, 3'b111, 64'h40, 64'd0);
        chk("ld_111_fault", 64'(Fault), 64'd1);
        chk("ld_111_data",  Read_Data, 64'd0);
        op(1'b0, 1'b1, 3'b100, 64'h40, 64'h55);
        chk("st_100_fault", 64'(Fault), 64'd1);
        op(1'b1, 1'b0, 3'b011, 64'h40, 64'd0);
        chk("st_100_nowrite", Read_Data, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("st_100_count",   64'(Store_Count), 64'd5);

        // Asynchronous reset between edges
        op(1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
        #2;
        reset = 1'b0; MemRead = 1'b1; funct3 = 3'b011; Mem_Addr = 64'h10;
        #1;
        chk("mid_rst_read",   Read_Data, 64'd0);
        chk("mid_rst_count",  64'(Store_Count), 64'd0);
        chk("mid_rst_sticky", 64'(Fault_Sticky), 64'd0);
        @(negedge clk);
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'b011;
        Mem_Addr = 64'h30; Write_Data = 64'h5A;
        op(1'b1, 1'b0, 3'b011, 64'h30, 64'd0);
        chk("post_rst_store", Read_Data, 64'h5A);
        chk("post_rst_count", 64'(Store_Count), 64'd1);
        op(1'b1, 1'b0, 3'b011, 64'h10, 64'd0);
        chk("post_rst_cleared", Read_Data, 64'd0);
        chk("post_rst_sticky",  64'(Fault_Sticky), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
